matrix_loader: RTL
==================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have parameter ELEM_W, default 8, meaning signed element width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin loading one matrix.
REQ-005 SHALL have port size  input  3  matrix order N; legal values 2..5; sampled on accepted start.
REQ-006 SHALL have port in_valid  input  1  in_data holds a valid element.
REQ-007 SHALL have port in_data  input  ELEM_W  signed element, row-major order.
REQ-008 SHALL have port in_ready  output  1  loader accepts an element this cycle.
REQ-009 SHALL have port matrix  output  25*ELEM_W  packed matrix for the det2..det5 consumers.
REQ-010 SHALL have port matrix_valid  output  1  matrix is complete and stable.
REQ-011 SHALL have port busy  output  1  load in progress.
REQ-012 SHALL have port err  output  1  last start carried an illegal size.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-014 IDLE: in_ready=0, busy=0, matrix_valid=0; start with size in 2..5 -> LOAD next cycle; latch N; row=col=0; err cleared.
REQ-015 IDLE or DONE: start with size 0, 1, 6 or 7 -> go to or stay in IDLE; err=1 next cycle; matrix unchanged.
REQ-016 LOAD: in_ready=1, busy=1; a handshake occurs on in_valid && in_ready.
REQ-017 Each handshake SHALL write in_data to element k=row*N+col; then col+1, or col=0 and row+1 when col==N-1.
REQ-018 Element k SHALL occupy bits [N*N*ELEM_W-1-k*ELEM_W -: ELEM_W]: dense row-major, MSB-first, so the N*N block sits at the LSB end (matrix[127:0] for N=4).
REQ-019 in_valid=0 in LOAD SHALL stall without changing state, counters or matrix.
REQ-020 Handshake on element (N-1,N-1) SHALL move to DONE; matrix_valid=1 and the final element visible on the next cycle (latency 1).
REQ-021 DONE: in_ready=0, busy=0, matrix_valid=1; matrix held; holds until start or reset.
REQ-022 start in DONE with legal size SHALL act as in IDLE: matrix_valid drops the next cycle.
REQ-023 start during LOAD SHALL be ignored; size is not resampled.
REQ-024 Bits above N*N*ELEM_W SHALL be governed by REQ-030/031 only; element data SHALL be stored verbatim, with no arithmetic or overflow handling.

Reset
REQ-025 rst=0 at a clock edge SHALL force IDLE, row=col=0, N=0.
REQ-026 Reset SHALL drive matrix to all zeros, in_ready=0, matrix_valid=0, busy=0, err=0.
REQ-027 Reset during LOAD SHALL discard the partial matrix; a handshake in the same cycle SHALL be lost.
REQ-028 Reset SHALL take priority over start and handshake in the same cycle.

Configuration
REQ-029 SHALL support macro MATRIX_LOADER_CLEAR_EN.
REQ-030 With MATRIX_LOADER_CLEAR_EN defined: accepted legal start SHALL zero all 25*ELEM_W bits of matrix in that cycle.
REQ-031 Without it: accepted start SHALL leave matrix unchanged; only the positions written by handshakes change; stale bits above N*N*ELEM_W persist.

Verification
REQ-032 Reset, start size=3, feed 1..9 with in_valid always high -> in_ready high for 9 cycles; matrix[71:0]=0x010203040506070809; matrix_valid one cycle after the 9th handshake.
REQ-033 size=5, feed 25 elements with in_valid toggling 1,0 -> 25 handshakes only on valid cycles; matrix[199:192]=element 0, matrix[7:0]=element 24; no extra writes.
REQ-034 start size=6 in IDLE -> err=1 next cycle, in_ready=0, state IDLE; next start size=2 -> err=0.
REQ-035 size=4 load of all 0xFF, then size=2 load of 1,2,3,4 -> with CLEAR_EN, matrix=0x01020304 and upper bits 0; without, matrix[31:0]=0x01020304 and bits [127:32] remain all 0xFF.
REQ-036 rst low after 5 handshakes of a size=3 load -> next cycle matrix=0, busy=0, in_ready=0; a new size=3 load starts at element 0.
REQ-037 start pulsed mid-load with size=2 during a size=3 load -> ignored; load completes after 9 handshakes.

Source files
------------

// File: rtl/matrix_loader.sv
// matrix_loader: gathers an N x N signed matrix (N=2..5) one element per handshake into a packed row-major bus.
// Optional macro MATRIX_LOADER_CLEAR_EN zeroes the whole bus when a legal start is accepted.
module matrix_loader #(
    parameter int ELEM_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            size,
    input  logic                  in_valid,
    input  logic [ELEM_W-1:0]     in_data,
    output logic                  in_ready,
    output logic [25*ELEM_W-1:0]  matrix,
    output logic                  matrix_valid,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            n_q, n_d;
    logic [2:0]            row_q, row_d;
    logic [2:0]            col_q, col_d;
    logic [25*ELEM_W-1:0]  matrix_q, matrix_d;
    logic                  err_q, err_d;

    logic                  size_ok;
    logic                  hs;
    logic                  last;
    logic [5:0]            nsq;
    logic [5:0]            kidx;
    logic [5:0]            slot;

    assign size_ok = (size >= 3'd2) && (size <= 3'd5);
    assign hs      = (state_q == LOAD) && in_valid;
    assign nsq     = {3'b000, n_q} * {3'b000, n_q};
    assign kidx    = {3'b000, row_q} * {3'b000, n_q} + {3'b000, col_q};
    // Element k lives MSB-first inside the N*N block, so its slot counts down from the block top.
    assign slot    = nsq - kidx - 6'd1;
    assign last    = (row_q == n_q - 3'd1) && (col_q == n_q - 3'd1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            n_q      <= 3'd0;
            row_q    <= 3'd0;
            col_q    <= 3'd0;
            matrix_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            row_q    <= row_d;
            col_q    <= col_d;
            matrix_q <= matrix_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        row_d    = row_q;
        col_d    = col_q;
        matrix_d = matrix_q;
        err_d    = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (size_ok) begin
                        state_d = LOAD;
                        n_d     = size;
                        row_d   = 3'd0;
                        col_d   = 3'd0;
                        err_d   = 1'b0;
`ifdef MATRIX_LOADER_CLEAR_EN
                        matrix_d = '0;
`endif
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (hs) begin
                    for (int i = 0; i < 25; i++) begin
                        if (slot == i[5:0]) begin
                            matrix_d[i*ELEM_W +: ELEM_W] = in_data;
                        end
                    end
                    if (last) begin
                        state_d = DONE;
                        row_d   = 3'd0;
                        col_d   = 3'd0;
                    end else if (col_q == n_q - 3'd1) begin
                        col_d = 3'd0;
                        row_d = row_q + 3'd1;
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready     = (state_q == LOAD);
    assign busy         = (state_q == LOAD);
    assign matrix_valid = (state_q == DONE);
    assign matrix       = matrix_q;
    assign err          = err_q;

endmodule
